// File: rtl/window_feeder.sv
`default_nettype none
// ------------------------------------------------------------------------
// window_feeder : cuts a 2-bit nucleotide stream into overlapping windows
//                 and sequences the top_level LSH core.     Rev 1.0
// ------------------------------------------------------------------------
module window_feeder #(
  parameter int WINDOW_SIZE              = 128,
  parameter int KMER_SIZE                = 16,
  parameter int MAX_WINDOWS_IN_REFERENCE = 512,
  parameter int MAX_WINDOWS_IN_READ      = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               seq_start,
  input  logic               seq_is_reference,
  input  logic               nuc_valid,
  output logic               nuc_ready,
  input  logic [1:0]         nuc_data,
  input  logic               nuc_last,
  output logic               busy,
  output logic [1:0]         window [WINDOW_SIZE],
  output logic [31:0]        window_id,
  output logic               ready_for_hashing,
  input  logic               hashing_is_done,
  output logic               is_insert,
  output logic               is_query,
  output logic               reset_window_hasher,
  output logic               reset_stats,
  output logic               calculate_matched_window,
  input  logic signed [31:0] matched_window_id,
  output logic signed [31:0] result_id,
  output logic               result_valid,
  output logic               seq_done,
  output logic               overflow
);
  localparam int              CW          = $clog2(WINDOW_SIZE + 1);
  localparam logic [CW-1:0]   FULL_CNT    = CW'(WINDOW_SIZE);
  localparam logic [CW-1:0]   OVERLAP_CNT = CW'(KMER_SIZE - 1);
  localparam logic [31:0]     REF_CAP     = 32'(MAX_WINDOWS_IN_REFERENCE);
  localparam logic [31:0]     READ_CAP    = 32'(MAX_WINDOWS_IN_READ);

  typedef enum logic [2:0] {
    S_IDLE, S_START_RST, S_FILL, S_HASH, S_COMMIT, S_GAP, S_HASHER_RST, S_FINISH
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           phase_q, phase_d;
  logic                 is_ref_q, is_ref_d;
  logic                 last_seen_q, last_seen_d;
  logic                 drain_q, drain_d;
  logic [CW-1:0]        fill_cnt_q, fill_cnt_d;
  logic [CW-1:0]        fill_next;
  logic [31:0]          window_id_q, window_id_d;
  logic                 overflow_q, overflow_d;
  logic signed [31:0]   result_id_q, result_id_d;
  logic [1:0]           window_q [WINDOW_SIZE];
  logic                 shift_en;
  logic [31:0]          cap;
  logic                 xfer;

  logic nuc_ready_q, busy_q, rfh_q, ins_q, qry_q, rwh_q, rst_q, calc_q, rv_q, done_q;
  logic nuc_ready_d, busy_d, rfh_d, ins_d, qry_d, rwh_d, rst_d, calc_d, rv_d, done_d;

  assign fill_next = fill_cnt_q + 1'b1;
  assign cap       = is_ref_q ? REF_CAP : READ_CAP;
  assign xfer      = nuc_valid && nuc_ready_q;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    is_ref_d    = is_ref_q;
    last_seen_d = last_seen_q;
    drain_d     = drain_q;
    fill_cnt_d  = fill_cnt_q;
    window_id_d = window_id_q;
    overflow_d  = overflow_q;
    result_id_d = result_id_q;
    shift_en    = 1'b0;
    unique case (state_q)
      S_IDLE: if (seq_start) begin
        state_d     = S_START_RST;
        phase_d     = 2'd0;
        is_ref_d    = seq_is_reference;
        window_id_d = '0;
        fill_cnt_d  = '0;
        overflow_d  = 1'b0;
        last_seen_d = 1'b0;
        drain_d     = 1'b0;
      end
      S_START_RST, S_COMMIT, S_HASHER_RST: begin
        phase_d = phase_q + 2'd1;
        if (phase_q == 2'd1) begin
          phase_d = 2'd0;
          state_d = (state_q == S_COMMIT) ? S_GAP : S_FILL;
        end
      end
      S_FILL: if (xfer) begin
        // After the window cap, nucleotides are swallowed until the read ends
        if (drain_q) begin
          if (nuc_last) state_d = S_FINISH;
        end else begin
          shift_en   = 1'b1;
          fill_cnt_d = fill_next;
          if (fill_next == FULL_CNT) begin
            state_d     = S_HASH;
            last_seen_d = nuc_last;
          end else if (nuc_last) begin
            state_d = S_FINISH;
          end
        end
      end
      S_HASH: if (hashing_is_done) begin
        state_d = S_COMMIT;
        phase_d = 2'd0;
      end
      S_GAP: begin
        phase_d = phase_q + 2'd1;
        if (phase_q == 2'd1) begin
          phase_d = 2'd0;
          if (last_seen_q) begin
            state_d = S_FINISH;
          end else if (window_id_q + 32'd1 == cap) begin
            overflow_d = 1'b1;
            drain_d    = 1'b1;
            state_d    = S_FILL;
          end else begin
            window_id_d = window_id_q + 32'd1;
            fill_cnt_d  = OVERLAP_CNT;
            state_d     = S_HASHER_RST;
          end
        end
      end
      S_FINISH: begin
        phase_d = phase_q + 2'd1;
        if (is_ref_q) begin
          state_d = S_IDLE;
          phase_d = 2'd0;
        end else if (phase_q == 2'd1) begin
          result_id_d = matched_window_id;
        end else if (phase_q == 2'd2) begin
          state_d = S_IDLE;
          phase_d = 2'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they appear registered
    nuc_ready_d = (state_d == S_FILL);
    busy_d      = (state_d != S_IDLE);
    rfh_d       = (state_d == S_HASH);
    ins_d       = (state_d == S_COMMIT) && is_ref_d;
    qry_d       = (state_d == S_COMMIT) && !is_ref_d;
    rwh_d       = (state_d == S_START_RST) || (state_d == S_HASHER_RST);
    rst_d       = (state_d == S_START_RST);
    calc_d      = (state_d == S_FINISH) && !is_ref_d && (phase_d != 2'd2);
    rv_d        = (state_d == S_FINISH) && !is_ref_d && (phase_d == 2'd2);
    done_d      = (state_d == S_FINISH) && (is_ref_d || (phase_d == 2'd2));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      phase_q     <= '0;
      is_ref_q    <= 1'b0;
      last_seen_q <= 1'b0;
      drain_q     <= 1'b0;
      fill_cnt_q  <= '0;
      window_id_q <= '0;
      overflow_q  <= 1'b0;
      result_id_q <= '1;
      window_q    <= '{default: '0};
      nuc_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      rfh_q       <= 1'b0;
      ins_q       <= 1'b0;
      qry_q       <= 1'b0;
      rwh_q       <= 1'b0;
      rst_q       <= 1'b0;
      calc_q      <= 1'b0;
      rv_q        <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      is_ref_q    <= is_ref_d;
      last_seen_q <= last_seen_d;
      drain_q     <= drain_d;
      fill_cnt_q  <= fill_cnt_d;
      window_id_q <= window_id_d;
      overflow_q  <= overflow_d;
      result_id_q <= result_id_d;
      nuc_ready_q <= nuc_ready_d;
      busy_q      <= busy_d;
      rfh_q       <= rfh_d;
      ins_q       <= ins_d;
      qry_q       <= qry_d;
      rwh_q       <= rwh_d;
      rst_q       <= rst_d;
      calc_q      <= calc_d;
      rv_q        <= rv_d;
      done_q      <= done_d;
      if (shift_en) begin
        for (int i = 0; i < WINDOW_SIZE - 1; i++) window_q[i] <= window_q[i+1];
        window_q[WINDOW_SIZE-1] <= nuc_data;
      end
    end
  end

  assign nuc_ready                = nuc_ready_q;
  assign busy                     = busy_q;
  assign window                   = window_q;
  assign window_id                = window_id_q;
  assign ready_for_hashing        = rfh_q;
  assign is_insert                = ins_q;
  assign is_query                 = qry_q;
  assign reset_window_hasher      = rwh_q;
  assign reset_stats              = rst_q;
  assign calculate_matched_window = calc_q;
  assign result_id                = result_id_q;
  assign result_valid             = rv_q;
  assign seq_done                 = done_q;
  assign overflow                 = overflow_q;

endmodule
`default_nettype wire
